// File: rtl/cell_fifo_rr_sched_pkg.sv
// Shared definitions for the cell FIFO round-robin read scheduler.
//   sched_state_e : scheduler FSM states (arbitrate / read a cell)
//   StatWidth     : width of each per-queue delivered-cell counter
//   SkidDepth     : entries in the output skid buffer
package cell_fifo_rr_sched_pkg;

    typedef enum logic {
        StArb  = 1'b0,
        StRead = 1'b1
    } sched_state_e;

    localparam int unsigned StatWidth = 16;
    localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/cell_fifo_rr_sched_if.sv
// Bundle between the scheduler, the per-port cell FIFOs and the egress cell stream.
//   empty/rdata     : FIFO -> scheduler (registered empty flags, per-FIFO read data)
//   ren/reoc/raddr  : scheduler -> FIFOs (one-hot read enable, end of cell, in-cell address)
//   cell_*          : valid/ready cell word stream towards egress, tagged qid/sop/eop
//   busy            : scheduler reading a cell or holding words
// master = scheduler side, slave = FIFO/egress side.
interface cell_fifo_rr_sched_if #(
    parameter int unsigned NUM_Q  = 4,
    parameter int unsigned QWIDTH = 2,
    parameter int unsigned CWIDTH = 2,
    parameter int unsigned DWIDTH = 8
);
    logic [NUM_Q-1:0]        empty;
    logic [NUM_Q-1:0]        ren;
    logic [NUM_Q-1:0]        reoc;
    logic [CWIDTH-1:0]       raddr;
    logic [NUM_Q*DWIDTH-1:0] rdata;
    logic                    cell_vld;
    logic                    cell_rdy;
    logic [DWIDTH-1:0]       cell_data;
    logic [QWIDTH-1:0]       cell_qid;
    logic                    cell_sop;
    logic                    cell_eop;
    logic                    busy;

    modport master (
        input  empty, rdata, cell_rdy,
        output ren, reoc, raddr, cell_vld, cell_data, cell_qid, cell_sop, cell_eop, busy
    );

    modport slave (
        output empty, rdata, cell_rdy,
        input  ren, reoc, raddr, cell_vld, cell_data, cell_qid, cell_sop, cell_eop, busy
    );
endinterface

// File: rtl/cell_fifo_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting queue at or after ptr, wrapping at NUM_Q-1.
//   req     : per-queue request mask
//   ptr     : highest-priority queue index (register held by the caller)
//   gnt     : one-hot grant, zero when nothing requests
//   gnt_id  : encoded grant
//   gnt_vld : any request present
module cell_fifo_rr_sched_rr_arbiter #(
    parameter int unsigned NUM_Q  = 4,
    parameter int unsigned QWIDTH = 2
) (
    input  logic [NUM_Q-1:0]  req,
    input  logic [QWIDTH-1:0] ptr,
    output logic [NUM_Q-1:0]  gnt,
    output logic [QWIDTH-1:0] gnt_id,
    output logic              gnt_vld
);
    logic [QWIDTH-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            idx = QWIDTH'((32'(ptr) + i) % NUM_Q);
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_id   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cell_fifo_rr_sched.sv
// Round-robin read scheduler for NUM_Q synchronous cell FIFOs (open-address mode).
// Grants one non-empty FIFO per cell, reads its 2**CWIDTH words in order and returns them on
// a valid/ready stream tagged with queue id, sop and eop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : cell_fifo_rr_sched_if.master (FIFO read side + output cell stream + busy)
//   stat_clr    : (CELL_SCHED_STAT_EN only) pulse clearing all delivered-cell counters
//   stat_cells  : (CELL_SCHED_STAT_EN only) per-queue 16-bit saturating delivered-cell counts
// Build option: define CELL_SCHED_STAT_EN to add the delivered-cell counters.
module cell_fifo_rr_sched
    import cell_fifo_rr_sched_pkg::*;
#(
    parameter int unsigned NUM_Q  = 4,
    parameter int unsigned QWIDTH = 2,
    parameter int unsigned CWIDTH = 2,
    parameter int unsigned DWIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef CELL_SCHED_STAT_EN
    input  logic                       stat_clr,
    output logic [NUM_Q*StatWidth-1:0] stat_cells,
`endif
    cell_fifo_rr_sched_if.master       bus
);
    typedef struct packed {
        logic [QWIDTH-1:0] qid;
        logic              sop;
        logic              eop;
        logic [DWIDTH-1:0] data;
    } word_t;

    sched_state_e      state_q;
    logic [QWIDTH-1:0] ptr_q;
    logic [QWIDTH-1:0] gnt_q;
    logic [NUM_Q-1:0]  gnt_oh_q;
    logic [CWIDTH-1:0] cnt_q;

    // Read in flight: FIFO data for this beat is on rdata this cycle.
    logic              rvld_q;
    logic [QWIDTH-1:0] rqid_q;
    logic              rsop_q;
    logic              reop_q;

    word_t             skid_q [SkidDepth];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        skid_cnt_q;

    logic [NUM_Q-1:0]  arb_gnt;
    logic [QWIDTH-1:0] arb_id;
    logic              arb_vld;
    logic              pop;
    logic              issue;
    logic              last_beat;
    logic [2:0]        credit;
    word_t             rword;
    word_t             head;

    cell_fifo_rr_sched_rr_arbiter #(
        .NUM_Q  (NUM_Q),
        .QWIDTH (QWIDTH)
    ) u_arb (
        .req     (~bus.empty),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        head      = skid_q[rd_ptr_q];
        pop       = (skid_cnt_q != '0) && bus.cell_rdy;
        // A word leaving this cycle frees its slot, which keeps one word per cycle in a cell.
        credit    = 3'(skid_cnt_q) + 3'(rvld_q) - 3'(pop);
        issue     = (state_q == StRead) && (credit < 3'(SkidDepth));
        last_beat = (cnt_q == '1);
        rword     = '{qid: rqid_q, sop: rsop_q, eop: reop_q,
                      data: bus.rdata[rqid_q*DWIDTH +: DWIDTH]};
    end

    assign bus.ren       = issue ? gnt_oh_q : '0;
    assign bus.reoc      = (issue && last_beat) ? gnt_oh_q : '0;
    assign bus.raddr     = issue ? cnt_q : '0;
    assign bus.cell_vld  = (skid_cnt_q != '0);
    assign bus.cell_data = head.data;
    assign bus.cell_qid  = head.qid;
    assign bus.cell_sop  = head.sop;
    assign bus.cell_eop  = head.eop;
    assign bus.busy      = (state_q == StRead) || (skid_cnt_q != '0);

    // Returning to arbitration after the last beat gives the FIFO a cycle to update empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StArb;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StArb: begin
                    if (arb_vld) begin
                        gnt_q    <= arb_id;
                        gnt_oh_q <= arb_gnt;
                        cnt_q    <= '0;
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    if (issue) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            ptr_q   <= (gnt_q == QWIDTH'(NUM_Q - 1)) ? '0 : gnt_q + 1'b1;
                            state_q <= StArb;
                        end
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvld_q <= 1'b0;
            rqid_q <= '0;
            rsop_q <= 1'b0;
            reop_q <= 1'b0;
        end else begin
            rvld_q <= issue;
            rqid_q <= gnt_q;
            rsop_q <= issue && (cnt_q == '0);
            reop_q <= issue && last_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SkidDepth; i++) begin
                skid_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            skid_cnt_q <= '0;
        end else begin
            if (rvld_q) begin
                skid_q[wr_ptr_q] <= rword;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            skid_cnt_q <= skid_cnt_q + 2'(rvld_q) - 2'(pop);
        end
    end

`ifdef CELL_SCHED_STAT_EN
    for (genvar q = 0; q < NUM_Q; q++) begin : g_stat
        logic [StatWidth-1:0] cells_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cells_q <= '0;
            end else if (stat_clr) begin
                cells_q <= '0;
            end else if (pop && head.eop && (head.qid == QWIDTH'(q)) && (cells_q != '1)) begin
                cells_q <= cells_q + 1'b1;
            end
        end

        assign stat_cells[q*StatWidth +: StatWidth] = cells_q;
    end
`endif

endmodule

// File: tb/tb_cell_fifo_rr_sched.sv
// Randomised bench for cell_fifo_rr_sched: behavioural FIFOs feed the scheduler, a cell-level
// round-robin model predicts the word stream into a scoreboard, and a monitor compares it.
module tb_cell_fifo_rr_sched;
    localparam int unsigned NUM_Q  = 4;
    localparam int unsigned QWIDTH = 2;
    localparam int unsigned CWIDTH = 2;
    localparam int unsigned DWIDTH = 8;
    localparam int unsigned CLEN   = 1 << CWIDTH;

    typedef struct packed {
        logic [QWIDTH-1:0] qid;
        logic              sop;
        logic              eop;
        logic [DWIDTH-1:0] data;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cell_fifo_rr_sched_if #(
        .NUM_Q  (NUM_Q),
        .QWIDTH (QWIDTH),
        .CWIDTH (CWIDTH),
        .DWIDTH (DWIDTH)
    ) bus ();

`ifdef CELL_SCHED_STAT_EN
    logic                   stat_clr = 1'b0;
    logic [NUM_Q*16-1:0]    stat_cells;
`endif

    cell_fifo_rr_sched #(
        .NUM_Q  (NUM_Q),
        .QWIDTH (QWIDTH),
        .CWIDTH (CWIDTH),
        .DWIDTH (DWIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CELL_SCHED_STAT_EN
        .stat_clr   (stat_clr),
        .stat_cells (stat_cells),
`endif
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural cell FIFOs (registered empty, read latency 1)
    logic [DWIDTH-1:0] fq   [NUM_Q][$];
    logic [DWIDTH-1:0] pend [NUM_Q][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_Q; q++) fq[q].delete();
            bus.empty <= '1;
            bus.rdata <= '0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (bus.ren[q]) begin
                    check("read_nonempty_fifo", 64'(fq[q].size() >= CLEN), 1);
                    if (fq[q].size() >= CLEN) bus.rdata[q*DWIDTH +: DWIDTH] <= fq[q][bus.raddr];
                    if (bus.reoc[q] && fq[q].size() >= CLEN) begin
                        repeat (CLEN) void'(fq[q].pop_front());
                    end
                end
                bus.empty[q] <= (fq[q].size() == 0);
            end
        end
    end

    // ---------------- reference model: round robin over whole cells
    word_t exp_q [$];
    int    model_ptr = 0;
    int    ld_cnt [NUM_Q];

    task automatic load_round();
        int rem [NUM_Q];
        int g;
        logic [DWIDTH-1:0] d;
        for (int q = 0; q < NUM_Q; q++) begin
            rem[q] = ld_cnt[q];
            for (int k = 0; k < ld_cnt[q] * int'(CLEN); k++) begin
                d = DWIDTH'($urandom);
                fq[q].push_back(d);
                pend[q].push_back(d);
            end
        end
        forever begin
            g = -1;
            for (int i = 0; i < NUM_Q; i++) begin
                if (g < 0 && rem[(model_ptr + i) % NUM_Q] > 0) g = (model_ptr + i) % NUM_Q;
            end
            if (g < 0) break;
            for (int w = 0; w < CLEN; w++) begin
                exp_q.push_back('{qid: QWIDTH'(g), sop: (w == 0), eop: (w == CLEN - 1),
                                  data: pend[g].pop_front()});
            end
            rem[g]--;
            model_ptr = (g + 1) % NUM_Q;
        end
    endtask

    // ---------------- ready driver
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low, 3: driven by main sequence
    initial begin
        bus.cell_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.cell_rdy = 1'b1;
                1:       bus.cell_rdy = 1'($urandom_range(0, 1));
                2:       bus.cell_rdy = 1'b0;
                default: ;
            endcase
        end
    end

    // ---------------- monitor
    int          cycle = 0;
    int          issued = 0;
    int          delivered = 0;
    int          beat_ctr = 0;
    int          first_hs = -1;
    int          last_hs = -1;
    logic        hold_pending = 1'b0;
    logic [12:0] held;
    word_t       e;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                check("stall_stable", {bus.cell_vld, bus.cell_qid, bus.cell_sop, bus.cell_eop,
                                       bus.cell_data}, held);
            end
            hold_pending = bus.cell_vld && !bus.cell_rdy;
            held = {1'b1, bus.cell_qid, bus.cell_sop, bus.cell_eop, bus.cell_data};

            if (bus.cell_vld && bus.cell_rdy) begin
                delivered++;
                if (first_hs < 0) first_hs = cycle;
                last_hs = cycle;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h with no word pending", bus.cell_data);
                end else begin
                    e = exp_q.pop_front();
                    check("cell_word", {bus.cell_qid, bus.cell_sop, bus.cell_eop, bus.cell_data}, e);
                end
            end

            if (bus.ren != '0) begin
                issued++;
                check("ren_onehot", 64'($onehot(bus.ren)), 1);
                check("raddr_seq", 64'(bus.raddr), 64'(beat_ctr));
                check("reoc_last_beat", bus.reoc, (beat_ctr == CLEN - 1) ? bus.ren : '0);
                check("outstanding_le2", 64'((issued - delivered) <= 2), 1);
                beat_ctr = (beat_ctr + 1) % CLEN;
            end else if (bus.reoc != '0) begin
                check("reoc_without_ren", bus.reoc, 0);
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 0);
        exp_q.delete();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_ren", bus.ren, 0);
    endtask

    task automatic check_outputs_zero();
        check("rst_ren", bus.ren, 0);
        check("rst_reoc", bus.reoc, 0);
        check("rst_raddr", bus.raddr, 0);
        check("rst_vld", bus.cell_vld, 0);
        check("rst_word", {bus.cell_qid, bus.cell_sop, bus.cell_eop, bus.cell_data}, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        repeat (4) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single queue Q2
        ld_cnt = '{0, 0, 1, 0};
        load_round();
        drain(100);

        // every queue two cells, always ready: 8 cells with one idle cycle between cells
        ld_cnt = '{2, 2, 2, 2};
        first_hs = -1;
        load_round();
        drain(200);
        check("throughput_span", 64'(last_hs - first_hs), 64'(8 * CLEN + 7 - 1));

        // downstream stall mid-cell
        ld_cnt = '{1, 1, 1, 1};
        load_round();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.cell_vld && bus.cell_rdy) found = 1;
        end
        check("stall_start_seen", 64'(found), 1);
        @(negedge clk);
        rdy_mode = 2;
        repeat (6) @(negedge clk);
        rdy_mode = 0;
        drain(200);

        // Q1 drains while Q3 waits
        rdy_mode = 1;
        ld_cnt = '{0, 1, 0, 1};
        load_round();
        drain(200);

        // random traffic
        for (int r = 0; r < 20; r++) begin
            rdy_mode = $urandom_range(0, 1);
            for (int q = 0; q < NUM_Q; q++) ld_cnt[q] = $urandom_range(0, 3);
            load_round();
            drain(600);
        end

        // asynchronous reset during beat 2 of a Q2 cell
        rdy_mode = 1;
        ld_cnt = '{0, 1, 1, 0};
        load_round();
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.ren[2] && bus.raddr == 2) found = 1;
        end
        check("rst_trigger_seen", 64'(found), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        exp_q.delete();
        model_ptr    = 0;
        issued       = 0;
        delivered    = 0;
        beat_ctr     = 0;
        hold_pending = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        @(negedge clk);
        ld_cnt = '{1, 1, 1, 1};
        load_round();
        drain(200);

`ifdef CELL_SCHED_STAT_EN
        check("stat_after_rst_q0", stat_cells[15:0], 1);
        check("stat_after_rst_q3", stat_cells[63:48], 1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr", stat_cells, 0);
        rdy_mode = 0;
        ld_cnt = '{3, 0, 0, 0};
        load_round();
        drain(200);
        check("stat_q0_three", stat_cells[15:0], 3);
        check("stat_others_zero", stat_cells[63:16], 0);

        // clear coinciding with an eop handshake
        rdy_mode = 3;
        bus.cell_rdy = 1'b0;
        ld_cnt = '{1, 0, 0, 0};
        load_round();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.cell_vld && bus.cell_eop) begin
                found = 1;
                stat_clr = 1'b1;
                bus.cell_rdy = 1'b1;
            end else begin
                bus.cell_rdy = bus.cell_vld;
            end
        end
        check("stat_eop_seen", 64'(found), 1);
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        bus.cell_rdy = 1'b0;
        rdy_mode = 0;
        drain(100);
        check("stat_clr_wins", stat_cells[15:0], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
